// File: rtl/ps2_key_rx_if.sv
// Bundle for the PS/2 pins and the decoded key-event outputs.
// master = receiver side, slave = pin driver / event consumer.
interface ps2_key_rx_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic [10:0] ps2_key;
  logic        frame_err;
  logic        busy;

  modport master (
    input  ps2_clk,
    input  ps2_data,
    output ps2_key,
    output frame_err,
    output busy
  );

  modport slave (
    output ps2_clk,
    output ps2_data,
    input  ps2_key,
    input  frame_err,
    input  busy
  );
endinterface

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: synchronizes and filters the raw line, frames bytes and
// decodes E0/F0/E1 prefixes into the 11-bit {toggle, pressed, ext, code} event word.
module ps2_key_rx #(
  parameter int unsigned FILTER  = 8,
  parameter int unsigned TIMEOUT = 96000
) (
  input logic          clk_sys,
  input logic          rst_n,
  ps2_key_rx_if.master bus
);

  localparam int unsigned FCW = $clog2(FILTER + 1);
  localparam int unsigned TCW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t           state, state_n;
  logic             clk_s1, clk_s2, dat_s1, dat_s2;
  logic             filt_lvl;
  logic [FCW-1:0]   filt_cnt;
  logic             flip_c, fall_c, timeout_c;
  logic [TCW-1:0]   idle_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       sreg;
  logic             par_ok;
  logic             start_c, shift_c, par_c, byte_ok_c, byte_bad_c;
  logic             ext, rel;
  logic [2:0]       skip;
  logic [10:0]      key_q;
  logic             err_q, busy_q;

  assign bus.ps2_key   = key_q;
  assign bus.frame_err = err_q;
  assign bus.busy      = busy_q;

  // 2-FF synchronizers, preset to the idle-high line level
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= bus.ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= bus.ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // Level flips in the cycle that holds the FILTER-th consecutive sample at the new level
  assign flip_c = (clk_s2 != filt_lvl) && (filt_cnt == FCW'(FILTER - 1));
  assign fall_c = flip_c && filt_lvl;

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      filt_lvl <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_s2 == filt_lvl) begin
      filt_cnt <= '0;
    end else if (flip_c) begin
      filt_lvl <= clk_s2;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + FCW'(1);
    end
  end

  // Saturating idle counter, cleared on every filtered falling edge
  assign timeout_c = (idle_cnt == TCW'(TIMEOUT));

  always_ff @(posedge clk_sys) begin
    if (!rst_n)          idle_cnt <= '0;
    else if (fall_c)     idle_cnt <= '0;
    else if (!timeout_c) idle_cnt <= idle_cnt + TCW'(1);
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next state; a falling edge takes priority over a coincident timeout
  always_comb begin
    state_n = state;
    if (fall_c) begin
      unique case (state)
        IDLE:    if (!dat_s2) state_n = DATA;
        DATA:    if (bit_cnt == 3'd7) state_n = PARITY;
        PARITY:  state_n = STOP;
        STOP:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end else if (timeout_c && (state != IDLE)) begin
      state_n = IDLE;
    end
  end

  // Datapath strobes decoded from the current state
  always_comb begin
    start_c    = 1'b0;
    shift_c    = 1'b0;
    par_c      = 1'b0;
    byte_ok_c  = 1'b0;
    byte_bad_c = 1'b0;
    unique case (state)
      IDLE:    start_c = fall_c && !dat_s2;
      DATA:    shift_c = fall_c;
      PARITY:  par_c   = fall_c;
      STOP: begin
        byte_ok_c  = fall_c && dat_s2 && par_ok;
        byte_bad_c = fall_c && !(dat_s2 && par_ok);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      sreg    <= '0;
      par_ok  <= 1'b0;
    end else begin
      if (start_c)      bit_cnt <= '0;
      else if (shift_c) bit_cnt <= bit_cnt + 3'd1;
      if (shift_c)      sreg    <= {dat_s2, sreg[7:1]};
      if (par_c)        par_ok  <= ^{sreg, dat_s2};
    end
  end

  // Prefix decoder and event word
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      ext    <= 1'b0;
      rel    <= 1'b0;
      skip   <= '0;
      key_q  <= '0;
      err_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      err_q  <= byte_bad_c;
      busy_q <= (state_n != IDLE);
      if (byte_bad_c) begin
        ext <= 1'b0;
        rel <= 1'b0;
      end else if (byte_ok_c) begin
        if (skip != 3'd0) begin
          skip <= skip - 3'd1;
        end else begin
          unique case (sreg)
            8'hE0:   ext  <= 1'b1;
            8'hF0:   rel  <= 1'b1;
            8'hE1:   skip <= 3'd7;
            default: begin
              key_q <= {~key_q[10], ~rel, ext, sreg};
              ext   <= 1'b0;
              rel   <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_rx.sv
// Directed bench for ps2_key_rx: drives PS/2 frames on the pins and checks the event word.
module tb_ps2_key_rx;

  localparam int unsigned FILTER  = 8;
  localparam int unsigned TIMEOUT = 400;
  localparam int unsigned HALF    = 40;

  logic clk_sys = 1'b0;
  logic rst_n   = 1'b0;

  ps2_key_rx_if bus ();

  ps2_key_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  int tests = 0;
  int fails = 0;
  int key_chg = 0;
  int err_cyc = 0;
  int busy_cyc = 0;
  int lat = 0;
  logic [10:0] last_key = '0;

  // Event counters sampled on the inactive edge
  always @(negedge clk_sys) begin
    if (bus.ps2_key !== last_key) key_chg = key_chg + 1;
    last_key = bus.ps2_key;
    if (bus.frame_err === 1'b1) err_cyc = err_cyc + 1;
    if (bus.busy === 1'b1) busy_cyc = busy_cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  // Bits go out LSB first; data changes while the clock is high
  task automatic send_bits(input logic [10:0] bits, input int nbits, input bit measure);
    logic [10:0] k0;
    for (int i = 0; i < nbits; i++) begin
      bus.ps2_data = bits[i];
      cycles(HALF);
      bus.ps2_clk = 1'b0;
      if (measure && i == 10) begin
        k0  = bus.ps2_key;
        lat = 0;
        for (int j = 1; j <= int'(HALF); j++) begin
          @(negedge clk_sys);
          if (lat == 0 && bus.ps2_key !== k0) lat = j;
        end
      end else begin
        cycles(HALF);
      end
      bus.ps2_clk = 1'b1;
    end
    cycles(HALF);
    bus.ps2_data = 1'b1;
  endtask

  function automatic logic [10:0] frame(input logic [7:0] b, input bit bad_par);
    logic p;
    p = (~^b) ^ bad_par;
    return {1'b1, p, b, 1'b0};
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit bad_par = 1'b0, input bit measure = 1'b0);
    send_bits(frame(b, bad_par), 11, measure);
    cycles(100);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, c0, b0;
    logic [7:0] pause_seq [8];
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    rst_n        = 1'b0;
    cycles(5);
    chk("rst_key", 32'(bus.ps2_key), 32'h000);
    chk("rst_err", 32'(bus.frame_err), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    cycles(20);

    // Press 0x29
    e0 = err_cyc;
    send_byte(8'h29, 1'b0, 1'b1);
    chk("press_key", 32'(bus.ps2_key), 32'h629);
    chk("press_lat", 32'(lat >= int'(FILTER) + 1 && lat <= int'(FILTER) + 4), 32'd1);
    chk("press_noerr", 32'(err_cyc - e0), 32'd0);

    // Release 0x29
    send_byte(8'hF0);
    chk("rel_prefix_hold", 32'(bus.ps2_key), 32'h629);
    send_byte(8'h29);
    chk("rel_key", 32'(bus.ps2_key), 32'h029);

    // Extended press and release
    send_byte(8'hE0);
    send_byte(8'h75);
    chk("ext_press", 32'(bus.ps2_key), 32'h775);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    chk("ext_rel", 32'(bus.ps2_key), 32'h175);

    // Parity error drops the byte and the E0 prefix
    send_byte(8'hE0);
    e0 = err_cyc;
    c0 = key_chg;
    send_byte(8'h1C, 1'b1);
    chk("par_err_pulse", 32'(err_cyc - e0), 32'd1);
    chk("par_err_hold", 32'(bus.ps2_key), 32'h175);
    send_byte(8'h1C);
    chk("par_next_key", 32'(bus.ps2_key), 32'h61C);
    chk("par_one_toggle", 32'(key_chg - c0), 32'd1);

    // Partial frame aborted by the idle timeout
    e0 = err_cyc;
    send_bits(frame(8'h5A, 1'b0), 5, 1'b0);
    chk("to_busy_mid", 32'(bus.busy), 32'd1);
    cycles(int'(TIMEOUT) + 10);
    chk("to_busy_clr", 32'(bus.busy), 32'd0);
    chk("to_noerr", 32'(err_cyc - e0), 32'd0);
    send_byte(8'h16);
    chk("to_next_key", 32'(bus.ps2_key), 32'h216);

    // Short clock glitches while idle
    b0 = busy_cyc;
    c0 = key_chg;
    for (int g = 0; g < 3; g++) begin
      bus.ps2_clk = 1'b0;
      cycles(3);
      bus.ps2_clk = 1'b1;
      cycles(30);
    end
    chk("glitch_busy", 32'(busy_cyc - b0), 32'd0);
    chk("glitch_noevt", 32'(key_chg - c0), 32'd0);

    // One-cycle reset in the middle of a frame
    send_bits(frame(8'h55, 1'b0), 4, 1'b0);
    rst_n = 1'b0;
    cycles(1);
    chk("mid_rst_key", 32'(bus.ps2_key), 32'h000);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_err", 32'(bus.frame_err), 32'd0);
    rst_n = 1'b1;
    cycles(50);
    send_byte(8'hF0);
    send_byte(8'h05);
    chk("post_rst_key", 32'(bus.ps2_key), 32'h405);

    // Pause sequence yields no event
    c0 = key_chg;
    foreach (pause_seq[i]) send_byte(pause_seq[i]);
    chk("pause_noevt", 32'(key_chg - c0), 32'd0);
    chk("pause_hold", 32'(bus.ps2_key), 32'h405);
    send_byte(8'h29);
    chk("after_pause_key", 32'(bus.ps2_key), 32'h229);
    chk("after_pause_toggle", 32'(key_chg - c0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
